// File: rtl/truth_sweep_ctrl_if.sv
// Host/function-unit bundle for truth_sweep_ctrl: host controls, the unit's response and sweep results.
// Slave modport belongs to the sequencer; master modport belongs to the host/test side.
interface truth_sweep_ctrl_if #(
   parameter int N_IN = 4
);
   logic                  start;
   logic                  abort;
   logic [2**N_IN-1:0]    exp_tt;
   logic                  func_in;
   logic [N_IN-1:0]       vec_out;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [N_IN:0]         err_cnt;
   logic [N_IN-1:0]       first_err_vec;
   logic                  first_err_valid;
   logic [2**N_IN-1:0]    resp_tt;

   modport slave (
      input  start, abort, exp_tt, func_in,
      output vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_valid, resp_tt
   );

   modport master (
      output start, abort, exp_tt, func_in,
      input  vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_valid, resp_tt
   );
endinterface

// File: rtl/truth_sweep_ctrl.sv
// Truth-table sweep sequencer: drives all 2**N_IN vectors into a combinational unit and checks each response.
// Latency: done pulses 2**N_IN*(SETTLE+1) cycles after the accepted start edge; each vector held SETTLE+1 cycles.
// No backpressure: start is ignored while busy, abort ends a sweep. TRUTH_SWEEP_GRAY_ORDER_EN selects Gray order.
module truth_sweep_ctrl #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   truth_sweep_ctrl_if.slave   bus
);
   localparam int NV = 2**N_IN;
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [SW-1:0]     cnt_q, cnt_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [N_IN:0]     err_q, err_d;
   logic [N_IN-1:0]   fvec_q, fvec_d;
   logic              fev_q, fev_d;
   logic [NV-1:0]     resp_q, resp_d;
   logic [NV-1:0]     exp_q, exp_d;

   logic [N_IN-1:0]   cur;
   logic              mis;
   logic [N_IN:0]     err_inc;

   function automatic logic [N_IN-1:0] seq(input logic [N_IN-1:0] i);
`ifdef TRUTH_SWEEP_GRAY_ORDER_EN
      return i ^ (i >> 1);
`else
      return i;
`endif
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fvec_q  <= '0;
         fev_q   <= 1'b0;
         resp_q  <= '0;
         exp_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fvec_q  <= fvec_d;
         fev_q   <= fev_d;
         resp_q  <= resp_d;
         exp_q   <= exp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fev_d   = fev_q;
      resp_d  = resp_q;
      exp_d   = exp_q;

      // Results are indexed by vector value, not by sweep step.
      cur     = seq(idx_q);
      mis     = (bus.func_in != exp_q[cur]);
      err_inc = err_q + (N_IN + 1)'(mis);

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               err_d   = '0;
               fev_d   = 1'b0;
               fvec_d  = '0;
               resp_d  = '0;
               pass_d  = 1'b0;
               exp_d   = bus.exp_tt;
               idx_d   = '0;
               vec_d   = seq('0);
               cnt_d   = SW'(SETTLE);
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               // Abort beats a coincident sample; partial results stay visible.
               state_d = IDLE;
               busy_d  = 1'b0;
               vec_d   = '0;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               resp_d[cur] = bus.func_in;
               err_d       = err_inc;
               if (mis && !fev_q) begin
                  fvec_d = cur;
                  fev_d  = 1'b1;
               end
               if (idx_q == '1) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_inc == '0);
               end else begin
                  idx_d = idx_q + 1'b1;
                  vec_d = seq(idx_q + 1'b1);
                  cnt_d = SW'(SETTLE);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.vec_out         = vec_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.pass            = pass_q;
   assign bus.err_cnt         = err_q;
   assign bus.first_err_vec   = fvec_q;
   assign bus.first_err_valid = fev_q;
   assign bus.resp_tt         = resp_q;
endmodule
